// File: rtl/vga_timing_gen_p_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared VGA definitions: 640x480@60 timing constants, total
//             period helpers, RGB332 field slices and RGB332->RGB888
//             expansion (also used by the test-pattern generator).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

  // 640x480@60 on a 25 MHz pixel clock
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_PULSE  = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_PULSE  = 2;
  localparam int VGA640_V_BACK   = 33;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb888_t;

  function automatic int h_total(input int active, input int front,
                                 input int pulse, input int back);
    return active + front + pulse + back;
  endfunction

  function automatic int v_total(input int active, input int front,
                                 input int pulse, input int back);
    return active + front + pulse + back;
  endfunction

  function automatic logic [2:0] rgb332_r(input logic [7:0] pix);
    return pix[7:5];
  endfunction

  function automatic logic [2:0] rgb332_g(input logic [7:0] pix);
    return pix[4:2];
  endfunction

  function automatic logic [1:0] rgb332_b(input logic [7:0] pix);
    return pix[1:0];
  endfunction

  // Bit replication keeps full-scale inputs at full scale (111 -> FF).
  function automatic rgb888_t expand_rgb332(input logic [7:0] pix);
    rgb888_t    res;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = rgb332_r(pix);
    g = rgb332_g(pix);
    b = rgb332_b(pix);
    res.red   = {r, r, r[2:1]};
    res.green = {g, g, g[2:1]};
    res.blue  = {b, b, b, b};
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_p_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_p_if
//  Purpose  : Pixel request bus between the timing generator (master) and
//             the framebuffer/zoom read path (slave).
//  Signals  : next_x/next_y/next_valid  requested coordinate
//             frame_start/line_start    request-side strobes
//             color_in                  RRRGGGBB returned by the read path
//  Revision : 1.0  initial release
// ============================================================================
interface vga_timing_gen_p_if #(
  parameter int CW = 10
);
  logic [CW-1:0] next_x;
  logic [CW-1:0] next_y;
  logic          next_valid;
  logic          frame_start;
  logic          line_start;
  logic [7:0]    color_in;

  modport master (
    output next_x, next_y, next_valid, frame_start, line_start,
    input  color_in
  );

  modport slave (
    input  next_x, next_y, next_valid, frame_start, line_start,
    output color_in
  );
endinterface
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : vga_delay_line
//  Purpose  : DEPTH-stage shift register with synchronous reset; DEPTH=0
//             collapses to a plain wire.
//  Ports    : clk   in   clock
//             rst   in   synchronous active-high reset (clears all stages)
//             din   in   WIDTH data in
//             dout  out  WIDTH data out, DEPTH cycles later
//  Revision : 1.0  initial release
// ============================================================================
module vga_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Clock and reset have no job without storage.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
          end
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen_p.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen_p
//  Purpose  : Parametrised VGA timing generator and pixel output stage.
//             Issues pixel coordinate requests, aligns sync/active with the
//             colour returned PIPE_LAT clocks later, expands RGB332 to
//             RGB888 and registers everything towards the DAC.
//  Ports    : clock      in   pixel clock
//             reset      in   synchronous active-high reset
//             req        --   request bus (master modport)
//             hsync      out  horizontal sync, HS_POL when asserted
//             vsync      out  vertical sync, VS_POL when asserted
//             red/green/blue out 8-bit DAC channels
//             blank      out  DAC BLANK_N, 1 while an active pixel is driven
//             sync       out  DAC SYNC_N, tied 0
//             clk        out  DAC clock, equals clock
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen_p
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FRONT  = VGA640_H_FRONT,
  parameter int H_PULSE  = VGA640_H_PULSE,
  parameter int H_BACK   = VGA640_H_BACK,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FRONT  = VGA640_V_FRONT,
  parameter int V_PULSE  = VGA640_V_PULSE,
  parameter int V_BACK   = VGA640_V_BACK,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 2,
  parameter int CW       = 10
) (
  input  logic                clock,
  input  logic                reset,
  vga_timing_gen_p_if.master  req,
  output logic                hsync,
  output logic                vsync,
  output logic [7:0]          red,
  output logic [7:0]          green,
  output logic [7:0]          blue,
  output logic                blank,
  output logic                sync,
  output logic                clk
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_PULSE, H_BACK);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_PULSE, V_BACK);

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FRONT + H_PULSE);
  localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FRONT + V_PULSE);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          active;
  logic          hs_req;
  logic          vs_req;
  logic [2:0]    align_in;
  logic [2:0]    align_out;
  logic          d_active;
  logic          d_hs;
  logic          d_vs;
  rgb888_t       pix;

  // --------------------------------------------------------------------------
  // Raster counters; v_cnt only moves on the line wrap, and a joint wrap
  // rolls straight into the next frame.
  // --------------------------------------------------------------------------
  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + CW'(1);
    end else begin
      h_cnt <= h_cnt + CW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Request-side decode (combinational from the counters)
  // --------------------------------------------------------------------------
  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_req = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
  assign vs_req = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);

  assign req.next_x      = active ? h_cnt : '0;
  assign req.next_y      = active ? v_cnt : '0;
  assign req.next_valid  = active;
  assign req.frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign req.line_start  = (h_cnt == '0) && (v_cnt < V_ACT);

  // --------------------------------------------------------------------------
  // Align active/sync with the colour that arrives PIPE_LAT clocks later so
  // sync edges stay pixel-exact relative to the picture.
  // --------------------------------------------------------------------------
  assign align_in = {active, hs_req, vs_req};

  vga_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (3)
  ) u_align (
    .clk  (clock),
    .rst  (reset),
    .din  (align_in),
    .dout (align_out)
  );

  assign {d_active, d_hs, d_vs} = align_out;

  always_comb begin
    pix = expand_rgb332(req.color_in);
  end

  // --------------------------------------------------------------------------
  // DAC output register: one extra clock after the colour sample point.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      blank <= 1'b0;
      hsync <= ~HS_POL;
      vsync <= ~VS_POL;
    end else begin
      red   <= d_active ? pix.red   : 8'h00;
      green <= d_active ? pix.green : 8'h00;
      blue  <= d_active ? pix.blue  : 8'h00;
      blank <= d_active;
      hsync <= d_hs ? HS_POL : ~HS_POL;
      vsync <= d_vs ? VS_POL : ~VS_POL;
    end
  end

  assign sync = 1'b0;
  assign clk  = clock;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen_p.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen_p
//  Purpose  : Scoreboard bench for vga_timing_gen_p. Instance 0 uses the
//             640x480 defaults with PIPE_LAT=2; instance 1 is a small
//             8/2/3/2 x 4/1/1/1 raster with HS_POL=1 and PIPE_LAT=0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen_p;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        bl;
    logic [23:0] rgb;
  } exp_t;

  // Framebuffer model returns PAT[x mod 4]; EXPC holds the hand-expanded
  // RGB888 value for each entry.
  localparam logic [7:0]  PAT  [4] = '{8'hE0, 8'h03, 8'h92, 8'h49};
  localparam logic [23:0] EXPC [4] = '{24'hFF0000, 24'h0000FF, 24'h9292AA, 24'h494955};

  logic       clk = 1'b0;
  logic [1:0] rst_v;
  logic [1:0] hs_v;
  logic [1:0] vs_v;
  logic [1:0] bl_v;
  logic [1:0] fs_v;
  logic [1:0] ls_v;

  int vectors = 0;
  int errors  = 0;

  always #20 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int HA  = (gi == 0) ? 640 : 8;
    localparam int HF  = (gi == 0) ? 16  : 2;
    localparam int HP  = (gi == 0) ? 96  : 3;
    localparam int HB  = (gi == 0) ? 48  : 2;
    localparam int VA  = (gi == 0) ? 480 : 4;
    localparam int VF  = (gi == 0) ? 10  : 1;
    localparam int VP  = (gi == 0) ? 2   : 1;
    localparam int VB  = (gi == 0) ? 33  : 1;
    localparam bit HSP = (gi == 0) ? 1'b0 : 1'b1;
    localparam bit VSP = 1'b0;
    localparam int LAT = (gi == 0) ? 2 : 0;
    localparam int HT  = HA + HF + HP + HB;
    localparam int VT  = VA + VF + VP + VB;

    vga_timing_gen_p_if #(.CW(10)) bus ();

    logic       hsync, vsync, blank, sync, clk_o;
    logic [7:0] red, green, blue;

    vga_timing_gen_p #(
      .H_ACTIVE (HA), .H_FRONT (HF), .H_PULSE (HP), .H_BACK (HB),
      .V_ACTIVE (VA), .V_FRONT (VF), .V_PULSE (VP), .V_BACK (VB),
      .HS_POL   (HSP), .VS_POL (VSP), .PIPE_LAT (LAT), .CW (10)
    ) u_dut (
      .clock (clk),
      .reset (rst_v[gi]),
      .req   (bus),
      .hsync (hsync),
      .vsync (vsync),
      .red   (red),
      .green (green),
      .blue  (blue),
      .blank (blank),
      .sync  (sync),
      .clk   (clk_o)
    );

    assign hs_v[gi] = hsync;
    assign vs_v[gi] = vsync;
    assign bl_v[gi] = blank;
    assign fs_v[gi] = bus.frame_start;
    assign ls_v[gi] = bus.line_start;

    int          hm;
    int          vm;
    logic        act;
    exp_t        q[$];
    exp_t        e;
    exp_t        idle;
    logic [9:0]  xh[$];
    logic [9:0]  xr;

    // Stimulus/model: advance the reference raster, check the request side,
    // queue the DAC response expected LAT+1 clocks later, drive colour.
    always @(negedge clk) begin
      idle.hs  = !HSP;
      idle.vs  = !VSP;
      idle.bl  = 1'b0;
      idle.rgb = 24'h0;
      if (rst_v[gi]) begin
        hm = 0;
        vm = 0;
        q.delete();
        for (int k = 0; k <= LAT; k++) q.push_back(idle);
      end else if (hm == HT - 1) begin
        hm = 0;
        vm = (vm == VT - 1) ? 0 : vm + 1;
      end else begin
        hm = hm + 1;
      end
      act = (hm < HA) && (vm < VA);
      chk($sformatf("req%0d", gi),
          {bus.next_x, bus.next_y, bus.next_valid, bus.frame_start, bus.line_start},
          {act ? 10'(hm) : 10'd0, act ? 10'(vm) : 10'd0, act,
           (hm == 0) && (vm == 0), (hm == 0) && (vm < VA)});
      e.hs  = (hm >= HA + HF && hm < HA + HF + HP) ? HSP : !HSP;
      e.vs  = (vm >= VA + VF && vm < VA + VF + VP) ? VSP : !VSP;
      e.bl  = act;
      e.rgb = act ? EXPC[hm % 4] : 24'h0;
      q.push_back(e);
      xh.push_front(bus.next_x);
      if (xh.size() > LAT + 1) void'(xh.pop_back());
      if (xh.size() > LAT) begin
        xr = xh[LAT];
        bus.color_in = PAT[xr[1:0]];
      end else begin
        bus.color_in = 8'hFF;
      end
    end

    // Monitor: the DAC side presents a pixel every clock.
    always @(negedge clk) begin
      #2;
      chk($sformatf("dacq%0d", gi), 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("dac%0d", gi), {hsync, vsync, blank, red, green, blue}, e);
      end
      chk($sformatf("syncclk%0d", gi), {sync, clk_o}, {1'b0, clk});
    end
  end

  task automatic wait_def(input int h, input int v);
    bit hit = 1'b0;
    for (int n = 0; n < 5000 && !hit; n++) begin
      @(negedge clk); #5;
      hit = (g_inst[0].hm == h) && (g_inst[0].vm == v);
    end
    chk("wait_def", 64'(hit), 64'd1);
  endtask

  task automatic wait_small(input int h, input int v);
    bit hit = 1'b0;
    for (int n = 0; n < 500 && !hit; n++) begin
      @(negedge clk); #5;
      hit = (g_inst[1].hm == h) && (g_inst[1].vm == v);
    end
    chk("wait_small", 64'(hit), 64'd1);
  endtask

  initial begin
    int hs_low, bl_hi, fall, ls_cnt, hs_hi, hs_first, vs_low, fs_next;
    logic prev;
    rst_v = 2'b11;
    repeat (4) @(negedge clk);
    #5 rst_v = 2'b00;

    // Default instance: one active line, measured at the DAC.
    wait_def(0, 1);
    hs_low = 0; bl_hi = 0; fall = -1; prev = hs_v[0];
    for (int j = 0; j < 800; j++) begin
      if (j > 0) begin @(negedge clk); #5; end
      if (!hs_v[0]) hs_low++;
      if (bl_v[0]) bl_hi++;
      if (prev && !hs_v[0] && fall < 0) fall = j;
      prev = hs_v[0];
    end
    chk("hs_low_clocks", 64'(hs_low), 64'd96);
    chk("blank_clocks", 64'(bl_hi), 64'd640);
    chk("hs_fall_offset", 64'(fall), 64'd659);

    // Mid-frame reset held 5 cycles in the middle of an active line.
    wait_def(300, 2);
    rst_v[0] = 1'b1;
    for (int r = 0; r < 5; r++) begin
      @(negedge clk); #5;
      chk("rst_sync", {hs_v[0], vs_v[0], bl_v[0]}, 3'b110);
      chk("rst_rgb", {g_inst[0].red, g_inst[0].green, g_inst[0].blue}, 24'h0);
    end
    rst_v[0] = 1'b0;
    chk("post_rst_req", {fs_v[0], g_inst[0].bus.next_x, g_inst[0].bus.next_y}, {1'b1, 20'h0});

    // Reset on the line-wrap cycle: v must not advance to 3.
    wait_def(799, 2);
    rst_v[0] = 1'b1;
    @(negedge clk); #5;
    rst_v[0] = 1'b0;
    chk("wrap_rst_def", {fs_v[0], g_inst[0].bus.next_y}, {1'b1, 10'd0});
    repeat (20) @(negedge clk);

    // Small instance: one whole frame from (0,0).
    wait_small(0, 0);
    ls_cnt = 0; hs_hi = 0; hs_first = -1; vs_low = 0; fs_next = -1;
    for (int j = 0; j <= 105; j++) begin
      if (j > 0) begin @(negedge clk); #5; end
      if (j > 0 && fs_v[1] && fs_next < 0) fs_next = j;
      if (j < 105) begin
        if (ls_v[1]) ls_cnt++;
        if (!vs_v[1]) vs_low++;
        if (j < 15 && hs_v[1]) begin
          hs_hi++;
          if (hs_first < 0) hs_first = j;
        end
      end
    end
    chk("small_frame_period", 64'(fs_next), 64'd105);
    chk("small_line_starts", 64'(ls_cnt), 64'd4);
    chk("small_hs_high", 64'(hs_hi), 64'd3);
    chk("small_hs_first", 64'(hs_first), 64'd11);
    chk("small_vs_low", 64'(vs_low), 64'd15);

    // Reset on the joint h/v wrap of the small instance.
    wait_small(14, 6);
    rst_v[1] = 1'b1;
    @(negedge clk); #5;
    rst_v[1] = 1'b0;
    chk("wrap_rst_small", {fs_v[1], bl_v[1]}, 2'b10);
    repeat (40) @(negedge clk);
    #10;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen_p.md
Name: vga_timing_gen_p

Overview:
- Parametrised VGA timing generator and pixel output stage; successor to the fixed 640x480 driver.
- Timing, sync polarity and colour-fetch latency are generic. Expands RRRGGGBB pixels to 8-bit channels and emits frame/line strobes.
- Sits between the framebuffer/zoom read path and the board's VGA DAC.
- Runs on the 25 MHz pixel clock.

Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in clocks.
- H_PULSE, 96: hsync width, in clocks.
- H_BACK, 48: horizontal back porch, in clocks.
- V_ACTIVE, 480: visible lines.
- V_FRONT, 10: vertical front porch, in lines.
- V_PULSE, 2: vsync width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- HS_POL, 0: asserted level of hsync.
- VS_POL, 0: asserted level of vsync.
- PIPE_LAT, 2: clocks from next_x/next_y to a valid color_in (range 0..8).
- CW, 10: coordinate/counter width. Must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clock  in  1  pixel clock; single clock domain.
- reset  in  1  synchronous, active-high.
- color_in  in  8  pixel RRRGGGBB, sampled PIPE_LAT cycles after its coordinate.
- next_x  out  CW  x of pixel being requested; 0 outside active.
- next_y  out  CW  y of pixel being requested; 0 outside active.
- next_valid  out  1  requested coordinate is inside the active area.
- frame_start  out  1  1-cycle pulse at request position (0,0).
- line_start  out  1  1-cycle pulse at x=0 of every active line.
- hsync  out  1  to VGA connector.
- vsync  out  1  to VGA connector.
- red  out  8  to DAC.
- green  out  8  to DAC.
- blue  out  8  to DAC.
- blank  out  1  DAC BLANK_N; 1 only while an active pixel is driven.
- sync  out  1  constant 0.
- clk  out  1  equals clock.

Behaviour:
- Totals: H_TOTAL = sum of H_* ; V_TOTAL = sum of V_*.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only on the h_cnt wrap cycle; it counts 0..V_TOTAL-1 and wraps to 0.
  - Simultaneous wrap of both counters starts the next frame with no gap.
- Region decode on the request side (h_cnt, v_cnt):
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs_req asserted for H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_PULSE.
  - vs_req asserted for V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_PULSE, for whole lines.
- Request outputs are combinational from the counters:
  - next_x = active ? h_cnt : 0; next_y = active ? v_cnt : 0; next_valid = active.
  - frame_start = (h_cnt==0 && v_cnt==0); line_start = (h_cnt==0 && v_cnt<V_ACTIVE).
- Alignment:
  - active, hs_req and vs_req pass through a PIPE_LAT-deep shift register.
  - color_in is sampled in the cycle its delayed active bit arrives.
  - All DAC-side outputs are registered once more, so the pixel for request cycle t appears at cycle t+PIPE_LAT+1.
  - Sync edges stay pixel-exact relative to colour.
- Colour expansion, when the delayed active bit is 1:
  - red = {r,r,r[2:1]}; green = {g,g,g[2:1]}; blue = {b,b,b,b}, where r=color_in[7:5], g=[4:2], b=[1:0].
  - When the delayed active bit is 0, all three channels are 0.
- Sync levels: hsync = delayed hs ? HS_POL : ~HS_POL; vsync likewise with VS_POL. blank = delayed active.
- Reset, synchronous, takes priority on any cycle including mid-frame:
  - h_cnt, v_cnt and all delay stages are set to 0.
  - red/green/blue=0, blank=0, hsync=~HS_POL, vsync=~VS_POL.
  - The first cycle after reset deasserts has request (0,0): frame_start=1, next_valid=1.
- PIPE_LAT=0: the delay line degenerates to a wire and latency is 1.

Decomposition:
- Shared package vga_pkg holds:
  - 640x480@60 timing constants and the H_TOTAL/V_TOTAL calculation functions.
  - The RGB332 field slices and the expansion function (reused by the test-pattern generator).
- One natural sub-module: vga_delay_line (parametrised depth and width, synchronous reset), used for the active/hs/vs alignment.

Test Plan:
- Reset: hold reset 5 cycles mid-frame -> hsync=1, vsync=1, rgb=0, blank=0. First post-reset cycle gives frame_start=1 and next_x=next_y=0.
- Horizontal timing, defaults: hsync low for exactly 96 clocks per 800-clock line. Falling edge at request cycle 656 appears at cycle 656+3. blank high for 640 clocks per line.
- Vertical timing, defaults: vsync low for 2 lines (1600 clocks). Frame period is 420000 clocks; line_start count per frame is 480.
- Colour path, PIPE_LAT=2, model returns color_in as a function of next_x delayed 2 cycles:
  - 0xE0 -> FF/00/00; 0x03 -> 00/00/FF; 0x92 -> 92/92/AA.
  - Any colour during porch -> 00/00/00.
- Small instance (H 8/2/3/2, V 4/1/1/1, HS_POL=1, PIPE_LAT=0):
  - Line is 15 clocks, frame is 105 clocks.
  - hsync is high at h_cnt 10..12, delayed 1 cycle.
  - Wrap from (14,6) to (0,0) pulses frame_start.
- Reset asserted on the h/v wrap cycle: the wrap is suppressed, counters are 0 next cycle, and no stale pixel is emitted from the delay line.
